// File: rtl/alu_issue_unit.sv
// alu_issue_unit
//   Sequencing front-end for the single-cycle ALU. Accepts a decoded
//   instruction slice over a valid/ready handshake, registers the ALU
//   operands and op, captures the ALU result one cycle later, resolves
//   the branch condition and returns the response over a second
//   valid/ready handshake. One request is in flight at a time.
//
//   Ports:
//     clk, reset            clock, asynchronous active-high reset
//     in_valid / in_ready   request handshake
//     opcode, funct3,       instruction fields (funct7_5 = bit 30)
//     funct7_5
//     rs1_val, rs2_val, imm source operands and sign-extended immediate
//     value1, value2,       registered ALU operands and op (to the ALU)
//     alu_op
//     finalValue, zero      ALU result and zero flag (from the ALU)
//     out_valid / out_ready response handshake
//     result, branch_taken, response payload
//     illegal
//
//   Build option: define ALU_ISSUE_BRANCH_EN to include branch decode and
//   branch_taken evaluation. Without it, branch opcodes decode as illegal
//   and branch_taken stays 0.

module alu_issue_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7_5,
   input  logic [31:0] rs1_val,
   input  logic [31:0] rs2_val,
   input  logic [31:0] imm,
   output logic [31:0] value1,
   output logic [31:0] value2,
   output logic [3:0]  alu_op,
   input  logic [31:0] finalValue,
   input  logic        zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] result,
   output logic        branch_taken,
   output logic        illegal
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SLL  = 4'b0101;
   localparam logic [3:0] OP_SRL  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   // Branch condition kinds; LT/GE cover both signed and unsigned since
   // the ALU op (SLT vs SLTU) already selects the comparison flavour.
   typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE} br_t;

   state_t      state_reg;
   br_t         br_reg;
   logic        pend_illegal_reg;

   logic [31:0] dec_v1;
   logic [31:0] dec_v2;
   logic [3:0]  dec_op;
   br_t         dec_br;
   logic        dec_illegal;
   logic        take_next;

   // Shared R/I arithmetic mapping; sub_ok distinguishes R-type (bit 30
   // selects SUB) from I-type (funct3 000 is always ADD).
   function automatic logic [3:0] arith_op(input logic [2:0] f3,
                                           input logic f7,
                                           input logic sub_ok);
      case (f3)
         3'b000:  arith_op = (sub_ok && f7) ? OP_SUB : OP_ADD;
         3'b001:  arith_op = OP_SLL;
         3'b010:  arith_op = OP_SLT;
         3'b011:  arith_op = OP_SLTU;
         3'b100:  arith_op = OP_XOR;
         3'b101:  arith_op = f7 ? OP_SRA : OP_SRL;
         3'b110:  arith_op = OP_OR;
         default: arith_op = OP_AND;
      endcase
   endfunction

   always_comb begin
      dec_v1      = '0;
      dec_v2      = '0;
      dec_op      = OP_ADD;
      dec_br      = BR_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         7'b0110011: begin
            dec_v1 = rs1_val;
            dec_v2 = rs2_val;
            dec_op = arith_op(funct3, funct7_5, 1'b1);
         end
         7'b0010011: begin
            dec_v1 = rs1_val;
            dec_v2 = imm;
            dec_op = arith_op(funct3, funct7_5, 1'b0);
         end
         7'b0000011, 7'b0100011: begin
            dec_v1 = rs1_val;
            dec_v2 = imm;
         end
`ifdef ALU_ISSUE_BRANCH_EN
         7'b1100011: begin
            case (funct3)
               3'b000:  begin dec_op = OP_SUB;  dec_br = BR_EQ; end
               3'b001:  begin dec_op = OP_SUB;  dec_br = BR_NE; end
               3'b100:  begin dec_op = OP_SLT;  dec_br = BR_LT; end
               3'b101:  begin dec_op = OP_SLT;  dec_br = BR_GE; end
               3'b110:  begin dec_op = OP_SLTU; dec_br = BR_LT; end
               3'b111:  begin dec_op = OP_SLTU; dec_br = BR_GE; end
               default: dec_illegal = 1'b1;
            endcase
            // Operands are only forwarded for decodable branches so an
            // illegal funct3 presents zeros to the ALU.
            if (!dec_illegal) begin
               dec_v1 = rs1_val;
               dec_v2 = rs2_val;
            end
         end
`endif
         default: dec_illegal = 1'b1;
      endcase
   end

   // Branch resolution from the ALU outputs during EXEC.
   always_comb begin
      case (br_reg)
         BR_EQ:   take_next = zero;
         BR_NE:   take_next = ~zero;
         BR_LT:   take_next = finalValue[0];
         BR_GE:   take_next = ~finalValue[0];
         default: take_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg        <= IDLE;
         br_reg           <= BR_NONE;
         pend_illegal_reg <= 1'b0;
         in_ready         <= 1'b1;
         out_valid        <= 1'b0;
         value1           <= '0;
         value2           <= '0;
         alu_op           <= OP_ADD;
         result           <= '0;
         branch_taken     <= 1'b0;
         illegal          <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  value1           <= dec_v1;
                  value2           <= dec_v2;
                  alu_op           <= dec_op;
                  br_reg           <= dec_br;
                  pend_illegal_reg <= dec_illegal;
                  in_ready         <= 1'b0;
                  state_reg        <= EXEC;
               end
            end
            EXEC: begin
               result       <= pend_illegal_reg ? 32'h0 : finalValue;
               branch_taken <= pend_illegal_reg ? 1'b0 : take_next;
               illegal      <= pend_illegal_reg;
               out_valid    <= 1'b1;
               state_reg    <= RESP;
            end
            RESP: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit
//   Directed bench for alu_issue_unit. A behavioural single-cycle ALU
//   closes the loop on value1/value2/alu_op -> finalValue/zero. Expected
//   values in the vector list are hand-computed.

module tb_alu_issue_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic        funct7_5 = 1'b0;
   logic [31:0] rs1_val = '0;
   logic [31:0] rs2_val = '0;
   logic [31:0] imm = '0;
   logic [31:0] value1;
   logic [31:0] value2;
   logic [3:0]  alu_op;
   logic [31:0] finalValue;
   logic        zero;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;
   logic        branch_taken;
   logic        illegal;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   alu_issue_unit dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode       (opcode),
      .funct3       (funct3),
      .funct7_5     (funct7_5),
      .rs1_val      (rs1_val),
      .rs2_val      (rs2_val),
      .imm          (imm),
      .value1       (value1),
      .value2       (value2),
      .alu_op       (alu_op),
      .finalValue   (finalValue),
      .zero         (zero),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .branch_taken (branch_taken),
      .illegal      (illegal)
   );

   // Behavioural ALU.
   always_comb begin
      case (alu_op)
         4'b0000: finalValue = value1 + value2;
         4'b0001: finalValue = value1 - value2;
         4'b0010: finalValue = value1 & value2;
         4'b0011: finalValue = value1 | value2;
         4'b0100: finalValue = value1 ^ value2;
         4'b0101: finalValue = value1 << value2[4:0];
         4'b0110: finalValue = value1 >> value2[4:0];
         4'b0111: finalValue = $unsigned($signed(value1) >>> value2[4:0]);
         4'b1000: finalValue = {31'b0, $signed(value1) < $signed(value2)};
         4'b1001: finalValue = {31'b0, value1 < value2};
         default: finalValue = 32'h0;
      endcase
      zero = (finalValue == 32'h0);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
   endtask

   // One full request/response transaction with optional back-pressure.
   task automatic run_req(input string name,
                          input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                          input logic [3:0] exp_op, input logic [31:0] exp_res,
                          input logic exp_tk, input logic exp_ill, input int hold);
      logic [31:0] held;
      @(negedge clk);
      check({name, ".in_ready_idle"}, {31'b0, in_ready}, 32'h1);
      opcode = op; funct3 = f3; funct7_5 = f7;
      rs1_val = a; rs2_val = b; imm = im;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({name, ".in_ready_exec"}, {31'b0, in_ready}, 32'h0);
      check({name, ".out_valid_exec"}, {31'b0, out_valid}, 32'h0);
      check({name, ".alu_op"}, {28'b0, alu_op}, {28'b0, exp_op});
      if (exp_ill) begin
         check({name, ".value1_ill"}, value1, 32'h0);
         check({name, ".value2_ill"}, value2, 32'h0);
      end
      @(posedge clk); #1;
      check({name, ".out_valid"}, {31'b0, out_valid}, 32'h1);
      check({name, ".result"}, result, exp_res);
      check({name, ".branch_taken"}, {31'b0, branch_taken}, {31'b0, exp_tk});
      check({name, ".illegal"}, {31'b0, illegal}, {31'b0, exp_ill});
      held = result;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({name, ".bp_valid"}, {31'b0, out_valid}, 32'h1);
         check({name, ".bp_result"}, result, held);
         check({name, ".bp_in_ready"}, {31'b0, in_ready}, 32'h0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({name, ".done_valid"}, {31'b0, out_valid}, 32'h0);
      check({name, ".done_in_ready"}, {31'b0, in_ready}, 32'h1);
      check({name, ".value1_hold"}, value1, exp_ill ? 32'h0 : a);
      $display("txn %-8s op=%07b f3=%03b a=%08h b=%08h imm=%08h -> alu_op=%04b result=%08h taken=%0d illegal=%0d",
               name, op, f3, a, b, im, exp_op, exp_res, exp_tk, exp_ill);
   endtask

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst.in_ready", {31'b0, in_ready}, 32'h1);
      check("rst.out_valid", {31'b0, out_valid}, 32'h0);
      reset = 1'b0;

      run_req("sub", 7'b0110011, 3'b000, 1'b1, 32'd5, 32'd7, 32'h0,
              4'b0001, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
      run_req("srai", 7'b0010011, 3'b101, 1'b1, 32'h80000000, 32'h0, 32'd4,
              4'b0111, 32'hF8000000, 1'b0, 1'b0, 0);
      run_req("addi_f7", 7'b0010011, 3'b000, 1'b1, 32'h10, 32'h0, 32'h20,
              4'b0000, 32'h30, 1'b0, 1'b0, 0);
      run_req("xor", 7'b0110011, 3'b100, 1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,
              4'b0100, 32'hFF00FF00, 1'b0, 1'b0, 0);
      run_req("load", 7'b0000011, 3'b010, 1'b0, 32'h100, 32'hDEAD, 32'h4,
              4'b0000, 32'h104, 1'b0, 1'b0, 5);
      run_req("illegal", 7'b1111111, 3'b000, 1'b0, 32'h12345678, 32'h1, 32'h1,
              4'b0000, 32'h0, 1'b0, 1'b1, 0);
`ifdef ALU_ISSUE_BRANCH_EN
      run_req("beq", 7'b1100011, 3'b000, 1'b0, 32'd3, 32'd3, 32'h0,
              4'b0001, 32'h0, 1'b1, 1'b0, 0);
      run_req("bltu", 7'b1100011, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0,
              4'b1001, 32'h0, 1'b0, 1'b0, 0);
      run_req("blt", 7'b1100011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h0,
              4'b1000, 32'h1, 1'b1, 1'b0, 0);
      run_req("bge", 7'b1100011, 3'b101, 1'b0, 32'd5, 32'd3, 32'h0,
              4'b1000, 32'h0, 1'b1, 1'b0, 0);
      run_req("br_ill", 7'b1100011, 3'b010, 1'b0, 32'd5, 32'd3, 32'h0,
              4'b0000, 32'h0, 1'b0, 1'b1, 0);
`else
      run_req("beq_off", 7'b1100011, 3'b000, 1'b0, 32'd3, 32'd3, 32'h0,
              4'b0000, 32'h0, 1'b0, 1'b1, 0);
`endif

      // Reset asserted mid-EXEC discards the request.
      @(negedge clk);
      opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
      rs1_val = 32'd9; rs2_val = 32'd9;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mid.in_ready_exec", {31'b0, in_ready}, 32'h0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("mid.in_ready", {31'b0, in_ready}, 32'h1);
      check("mid.out_valid", {31'b0, out_valid}, 32'h0);
      check("mid.value1", value1, 32'h0);
      check("mid.value2", value2, 32'h0);
      check("mid.alu_op", {28'b0, alu_op}, 32'h0);
      check("mid.result", result, 32'h0);
      check("mid.taken_ill", {30'b0, branch_taken, illegal}, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("mid.no_resp", {31'b0, out_valid}, 32'h0);
      $display("txn reset_mid_exec -> all outputs cleared");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
